// File: rtl/scan_loader.sv
// Configuration scan-chain feeder: accepts words over valid/ready and shifts CHAIN_LEN bits onto se/si.
// Define SCAN_READBACK_EN to capture the previous chain contents from so and emit them as words.
module scan_loader #(
  parameter int unsigned CHAIN_LEN  = 92,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  se,
  output logic                  si,
  input  logic                  so,
  output logic                  busy,
  output logic                  cfg_done
`ifdef SCAN_READBACK_EN
  ,
  output logic [DATA_WIDTH-1:0] rdbk_data,
  output logic                  rdbk_valid,
  output logic                  rdbk_last
`endif
);

  localparam int unsigned WORDS = (CHAIN_LEN + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned REM   = CHAIN_LEN - (WORDS - 1) * DATA_WIDTH;
  localparam int unsigned PW    = $clog2(DATA_WIDTH);
  localparam int unsigned WCW   = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [CNT_WIDTH-1:0]  bit_cnt, bit_cnt_n;
  logic [WCW-1:0]        word_cnt, word_cnt_n;
  logic [PW-1:0]         pos_cnt, pos_cnt_n;
  logic                  se_n, si_n, ready_n, busy_n, done_n;
  logic                  abort_c, last_word_c, word_end_c, chain_end_c;

  assign abort_c     = abort && (state != IDLE);
  assign last_word_c = (word_cnt == WCW'(WORDS - 1));
  assign chain_end_c = (bit_cnt == CNT_WIDTH'(CHAIN_LEN - 1));
  assign word_end_c  = (state == SHIFT) &&
                       (last_word_c ? (pos_cnt == PW'(REM - 1)) : (pos_cnt == PW'(DATA_WIDTH - 1)));

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      pos_cnt   <= '0;
      se        <= 1'b0;
      si        <= 1'b0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      word_cnt  <= word_cnt_n;
      pos_cnt   <= pos_cnt_n;
      se        <= se_n;
      si        <= si_n;
      cfg_ready <= ready_n;
      busy      <= busy_n;
      cfg_done  <= done_n;
    end
  end

  // Next state; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    pos_cnt_n  = pos_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = WAIT_WORD;
          shreg_n    = '0;
          bit_cnt_n  = '0;
          word_cnt_n = '0;
          pos_cnt_n  = '0;
        end
      end
      WAIT_WORD: begin
        if (cfg_valid) begin
          // The short last word is left-aligned so its top REM bits shift out first
          shreg_n   = last_word_c ? (cfg_data << (DATA_WIDTH - REM)) : cfg_data;
          pos_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_n   = shreg << 1;
        bit_cnt_n = bit_cnt + CNT_WIDTH'(1);
        pos_cnt_n = pos_cnt + PW'(1);
        if (word_end_c) begin
          pos_cnt_n = '0;
          if (chain_end_c) begin
            state_n = DONE;
          end else begin
            word_cnt_n = word_cnt + WCW'(1);
            state_n    = WAIT_WORD;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (abort_c) begin
      state_n    = IDLE;
      shreg_n    = '0;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
      pos_cnt_n  = '0;
    end

    se_n    = (state_n == SHIFT);
    si_n    = se_n & shreg_n[DATA_WIDTH-1];
    ready_n = (state_n == WAIT_WORD);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
  end

`ifdef SCAN_READBACK_EN
  logic [DATA_WIDTH-1:0] rb_q;

  // so is sampled on each shifting edge; word boundaries follow the outgoing word layout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_q       <= '0;
      rdbk_data  <= '0;
      rdbk_valid <= 1'b0;
      rdbk_last  <= 1'b0;
    end else begin
      rdbk_valid <= 1'b0;
      rdbk_last  <= 1'b0;
      if (abort_c) begin
        rb_q <= '0;
      end else if (se) begin
        if (word_end_c) begin
          rdbk_data  <= {rb_q[DATA_WIDTH-2:0], so};
          rdbk_valid <= 1'b1;
          rdbk_last  <= chain_end_c;
          rb_q       <= '0;
        end else begin
          rb_q <= {rb_q[DATA_WIDTH-2:0], so};
        end
      end
    end
  end
`else
  logic unused_so;
  assign unused_so = so;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Directed self-checking bench for scan_loader with a behavioural model of the scan chain.
`timescale 1ns/1ps
module tb_scan_loader;
  localparam int unsigned CL = 92;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 7;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic cfg_ready, se, si, so, busy, cfg_done;
  logic [CL-1:0] chain = '0;
  int se_cnt = 0, done_cnt = 0, cyc = 0;
  int checks = 0, errors = 0;
  logic [DW-1:0] img_a [6] = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h0F3C};
  logic [DW-1:0] img_b [6] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hFABC};

`ifdef SCAN_READBACK_EN
  logic [DW-1:0] rdbk_data;
  logic rdbk_valid, rdbk_last;
  logic [DW-1:0] rb_words [8];
  logic rb_lasts [8];
  int rb_n = 0;
`endif

  scan_loader #(.CHAIN_LEN(CL), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .se(se), .si(si), .so(so), .busy(busy), .cfg_done(cfg_done)
`ifdef SCAN_READBACK_EN
    , .rdbk_data(rdbk_data), .rdbk_valid(rdbk_valid), .rdbk_last(rdbk_last)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: first bit shifted in ends at the tail, which drives so
  assign so = chain[CL-1];
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    se_cnt   <= se_cnt + int'(se);
    done_cnt <= done_cnt + int'(cfg_done);
    if (se) chain <= {chain[CL-2:0], si};
  end

`ifdef SCAN_READBACK_EN
  always @(posedge clk) begin
    if (rdbk_valid) begin
      rb_words[rb_n % 8] <= rdbk_data;
      rb_lasts[rb_n % 8] <= rdbk_last;
      rb_n <= rb_n + 1;
    end
  end
`endif

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap);
    int g = 0;
    while (!cfg_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("ready_for_word", cfg_ready, 1'b1);
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      chk("gap_se_low", se, 1'b0);
    end
    cfg_data  = w;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data  = '0;
  endtask

  task automatic load(input logic [DW-1:0] img [6], input int gap_word, input int gap_len,
                      input bit poke);
    int s0, d0, t0, t1, g;
    logic [CL-1:0] gold;
    gold = {img[0], img[1], img[2], img[3], img[4], img[5][11:0]};
    s0 = se_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_start", cfg_ready, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      send_word(img[i], (i == gap_word) ? gap_len : 0);
      if (poke && i == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    g = 0;
    while (!cfg_done && g < 200) begin
      @(negedge clk);
      g++;
    end
    t1 = cyc;
    chk("done_seen", cfg_done, 1'b1);
    chk("se_low_in_done", se, 1'b0);
    chk("load_cycles", t1 - t0, 98 + gap_len);
    if (poke) begin
      cfg_valid = 1'b1;
      cfg_data  = 16'hFFFF;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data  = '0;
    chk("done_one_cycle", cfg_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", cfg_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("se_cycles", se_cnt - s0, 92);
    chk("done_pulses", done_cnt - d0, 1);
    chk("chain_image", chain, gold);
  endtask

  initial begin
    int s0, d0, g;
`ifdef SCAN_READBACK_EN
    int r0;
    logic [DW-1:0] expw;
`endif
    repeat (3) @(negedge clk);
    chk("rst_se", se, 1'b0);
    chk("rst_si", si, 1'b0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready_no_start", cfg_ready, 1'b0);

    // Full load, valid every cycle
    load(img_a, -1, 0, 1'b0);
    // Three-cycle valid gap before word 2
    load(img_a, 2, 3, 1'b0);

    // Abort on the 40th shift cycle
    s0 = se_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_word(img_a[i], 0);
    g = 0;
    while (!(se && (se_cnt - s0) == 39) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("abort_point", se_cnt - s0, 39);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_se", se, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cfg_ready, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_se_cycles", se_cnt - s0, 40);

    // Restart after abort, then stray start in SHIFT and stray valid in DONE
    load(img_b, -1, 0, 1'b0);
    load(img_a, -1, 0, 1'b1);

    // Asynchronous reset mid-shift
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(img_b[0], 0);
    @(negedge clk);
    chk("pre_reset_se", se, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_se", se, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", cfg_ready, 1'b0);

`ifdef SCAN_READBACK_EN
    load(img_a, -1, 0, 1'b0);
    r0 = rb_n;
    load(img_b, -1, 0, 1'b0);
    chk("rdbk_count", rb_n - r0, 6);
    for (int i = 0; i < 6; i++) begin
      expw = (i == 5) ? (img_a[i] & 16'h0FFF) : img_a[i];
      chk("rdbk_word", rb_words[(r0 + i) % 8], expw);
      chk("rdbk_last", rb_lasts[(r0 + i) % 8], (i == 5) ? 1'b1 : 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
